// File: rtl/pipelined_csel_addsub.sv
// Pipelined carry-select adder/subtractor: one SEG_W-bit segment per stage, with a
// registered carry between stages and valid/ready flow control on both sides.
module pipelined_csel_addsub #(
    parameter int WIDTH = 32,
    parameter int SEG_W = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);
    localparam int NSEG = WIDTH / SEG_W;
    localparam logic [SEG_W:0] ONE = {{SEG_W{1'b0}}, 1'b1};

    logic [WIDTH-1:0] b_eff;
    logic             accept;

    assign b_eff = b ^ {WIDTH{sub}};

    genvar gi;
    generate
        for (gi = 0; gi < NSEG; gi++) begin : g_stage
            // rem_*: operand bits not yet summed; sum_reg: completed low result bits
            localparam int REM_W = WIDTH - gi * SEG_W;
            localparam int LO_W  = (gi + 1) * SEG_W;

            logic [REM_W-1:0] rem_a;
            logic [REM_W-1:0] rem_b;
            logic             cin;
            logic             load;
            logic             down_free;
            logic             advance;
            logic             capture;
            logic [SEG_W:0]   sum0;
            logic [SEG_W:0]   sum1;
            logic [SEG_W:0]   sel;
            logic [LO_W-1:0]  sum_next;
            logic             valid_reg;
            logic             carry_reg;
            logic [LO_W-1:0]  sum_reg;

            if (gi == 0) begin : g_head
                assign rem_a    = a;
                assign rem_b    = b_eff;
                assign cin      = sub;
                assign load     = accept;
                assign sum_next = sel[SEG_W-1:0];
            end else begin : g_tail
                assign rem_a    = g_stage[gi-1].g_pass.a_reg;
                assign rem_b    = g_stage[gi-1].g_pass.b_reg;
                assign cin      = g_stage[gi-1].carry_reg;
                assign load     = g_stage[gi-1].advance;
                assign sum_next = {sel[SEG_W-1:0], g_stage[gi-1].sum_reg};
            end

            // A stage may move on if the stage after it is empty or moving on too
            if (gi == NSEG - 1) begin : g_sink
                assign down_free = out_ready;
            end else begin : g_mid
                assign down_free = !g_stage[gi+1].valid_reg || g_stage[gi+1].advance;
            end

            assign sum0    = {1'b0, rem_a[SEG_W-1:0]} + {1'b0, rem_b[SEG_W-1:0]};
            assign sum1    = {1'b0, rem_a[SEG_W-1:0]} + {1'b0, rem_b[SEG_W-1:0]} + ONE;
            assign sel     = cin ? sum1 : sum0;
            assign advance = valid_reg && down_free;
            assign capture = (!valid_reg || advance) && load;

            always_ff @(posedge clock or posedge reset) begin
                if (reset) begin
                    valid_reg <= 1'b0;
                    carry_reg <= 1'b0;
                    sum_reg   <= '0;
                end else begin
                    if (!valid_reg || advance) begin
                        valid_reg <= load;
                    end
                    if (capture) begin
                        carry_reg <= sel[SEG_W];
                        sum_reg   <= sum_next;
                    end
                end
            end

            if (gi < NSEG - 1) begin : g_pass
                logic [REM_W-SEG_W-1:0] a_reg;
                logic [REM_W-SEG_W-1:0] b_reg;

                always_ff @(posedge clock or posedge reset) begin
                    if (reset) begin
                        a_reg <= '0;
                        b_reg <= '0;
                    end else if (capture) begin
                        a_reg <= rem_a[REM_W-1:SEG_W];
                        b_reg <= rem_b[REM_W-1:SEG_W];
                    end
                end
            end else begin : g_last
                logic ovf_reg;
                logic zero_reg;

                // Carry into the MSB is a ^ b ^ sum at that bit; overflow is it XOR carry out
                always_ff @(posedge clock or posedge reset) begin
                    if (reset) begin
                        ovf_reg  <= 1'b0;
                        zero_reg <= 1'b0;
                    end else if (capture) begin
                        ovf_reg  <= rem_a[REM_W-1] ^ rem_b[REM_W-1] ^ sel[SEG_W-1] ^ sel[SEG_W];
                        zero_reg <= (sum_next == '0);
                    end
                end
            end
        end
    endgenerate

    assign in_ready  = !g_stage[0].valid_reg || g_stage[0].advance;
    assign accept    = in_valid && in_ready;
    assign out_valid = g_stage[NSEG-1].valid_reg;
    assign s         = g_stage[NSEG-1].sum_reg;
    assign cout      = g_stage[NSEG-1].carry_reg;
    assign ovf       = g_stage[NSEG-1].g_last.ovf_reg;
    assign zero      = g_stage[NSEG-1].g_last.zero_reg;

endmodule

// File: tb/tb_pipelined_csel_addsub.sv
// Bench for pipelined_csel_addsub (32-bit, 8-bit segments): scoreboard of expected
// results filled on accept and drained by a monitor on each output transfer.
module tb_pipelined_csel_addsub;
    localparam int WIDTH = 32;
    localparam int SEG_W = 8;

    logic             clock = 1'b0;
    logic             reset = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] a = '0;
    logic [WIDTH-1:0] b = '0;
    logic             sub = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [WIDTH-1:0] s;
    logic             cout;
    logic             ovf;
    logic             zero;

    typedef struct packed {
        logic [WIDTH-1:0] s;
        logic             cout;
        logic             ovf;
        logic             zero;
    } result_t;

    result_t sb[$];
    result_t mon_got;
    result_t mon_exp;
    int      checks = 0;
    int      errors = 0;

    pipelined_csel_addsub #(.WIDTH(WIDTH), .SEG_W(SEG_W)) dut (
        .clock(clock), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .sub(sub),
        .out_valid(out_valid), .out_ready(out_ready),
        .s(s), .cout(cout), .ovf(ovf), .zero(zero)
    );

    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    // Reference: wide add with two's-complement B, signed overflow from operand/result signs
    function automatic result_t model(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                      input logic op);
        logic [WIDTH:0]   wide;
        logic [WIDTH-1:0] yy;
        result_t          r;
        yy     = op ? ~y : y;
        wide   = {1'b0, x} + {1'b0, yy} + {{WIDTH{1'b0}}, op};
        r.s    = wide[WIDTH-1:0];
        r.cout = wide[WIDTH];
        r.ovf  = (x[WIDTH-1] == yy[WIDTH-1]) && (r.s[WIDTH-1] != x[WIDTH-1]);
        r.zero = (r.s == '0);
        return r;
    endfunction

    function automatic result_t mk(input logic [WIDTH-1:0] sv, input logic c, input logic o,
                                   input logic z);
        result_t r;
        r.s = sv; r.cout = c; r.ovf = o; r.zero = z;
        return r;
    endfunction

    task automatic set_op(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y, input logic op,
                          input logic v);
        a = x; b = y; sub = op; in_valid = v;
    endtask

    always @(negedge clock) begin
        if (!reset && out_valid && out_ready) begin
            mon_got.s = s; mon_got.cout = cout; mon_got.ovf = ovf; mon_got.zero = zero;
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL result_unexpected got s=%h cout=%b ovf=%b zero=%b required none",
                         s, cout, ovf, zero);
            end else begin
                mon_exp = sb.pop_front();
                if (mon_got !== mon_exp) begin
                    errors++;
                    $display("FAIL result got s=%h cout=%b ovf=%b zero=%b required s=%h cout=%b ovf=%b zero=%b",
                             s, cout, ovf, zero, mon_exp.s, mon_exp.cout, mon_exp.ovf, mon_exp.zero);
                end else begin
                    $display("result s=%h cout=%b ovf=%b zero=%b ok", s, cout, ovf, zero);
                end
            end
        end
    end

    task automatic test_reset();
        reset = 1'b1;
        out_ready = 1'b1;
        set_op(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b1);
        repeat (3) @(posedge clock);
        @(negedge clock);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++; $display("FAIL reset_out_valid got %b required 0", out_valid);
        end
        checks++;
        if ({s, cout, ovf, zero} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got s=%h cout=%b ovf=%b zero=%b required all 0",
                     s, cout, ovf, zero);
        end
        @(posedge clock); #1;
        reset = 1'b0;
        in_valid = 1'b0;
        @(negedge clock);
        checks++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL reset_in_ready got %b required 1", in_ready);
        end
        for (int c = 0; c < 6; c++) begin
            @(negedge clock);
            checks++;
            if (out_valid !== 1'b0) begin
                errors++; $display("FAIL reset_no_output cycle %0d got out_valid=%b required 0", c, out_valid);
            end
        end
    endtask

    task automatic test_directed();
        logic [WIDTH-1:0] va [6];
        logic [WIDTH-1:0] vb [6];
        logic             vs [6];
        result_t          ve [6];
        int               lat;
        logic             seen;
        va = '{32'h0000_FFFF, 32'd5, 32'd7, 32'h7FFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF};
        vb = '{32'd1, 32'd7, 32'd7, 32'd1, 32'd1, 32'd1};
        vs = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        ve[0] = mk(32'h0001_0000, 1'b0, 1'b0, 1'b0);
        ve[1] = mk(32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0);
        ve[2] = mk(32'h0000_0000, 1'b1, 1'b0, 1'b1);
        ve[3] = mk(32'h8000_0000, 1'b0, 1'b1, 1'b0);
        ve[4] = mk(32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0);
        ve[5] = mk(32'h0000_0000, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 6; i++) begin
            @(posedge clock); #1;
            set_op(va[i], vb[i], vs[i], 1'b1);
            out_ready = 1'b1;
            @(negedge clock);
            checks++;
            if (in_ready !== 1'b1) begin
                errors++; $display("FAIL directed_in_ready op %0d got %b required 1", i, in_ready);
            end else begin
                sb.push_back(ve[i]);
            end
            @(posedge clock); #1;
            in_valid = 1'b0;
            lat = 0;
            seen = 1'b0;
            for (int c = 1; c <= 10 && !seen; c++) begin
                @(negedge clock);
                if (out_valid === 1'b1) begin
                    seen = 1'b1;
                    lat = c;
                end
            end
            checks++;
            if (lat != 4) begin
                errors++; $display("FAIL directed_latency op %0d got %0d required 4", i, lat);
            end
        end
        @(posedge clock); #1;
    endtask

    task automatic test_stream();
        logic [WIDTH-1:0] ra [10];
        logic [WIDTH-1:0] rb [10];
        logic             rs [10];
        logic             exp_valid;
        for (int i = 0; i < 10; i++) begin
            ra[i] = $urandom;
            rb[i] = $urandom;
            rs[i] = 1'($urandom_range(0, 1));
        end
        for (int c = 0; c < 16; c++) begin
            @(posedge clock); #1;
            out_ready = 1'b1;
            if (c < 10) set_op(ra[c], rb[c], rs[c], 1'b1);
            else        in_valid = 1'b0;
            @(negedge clock);
            if (c < 10) begin
                checks++;
                if (in_ready !== 1'b1) begin
                    errors++; $display("FAIL stream_in_ready cycle %0d got %b required 1", c, in_ready);
                end else begin
                    sb.push_back(model(ra[c], rb[c], rs[c]));
                end
            end
            exp_valid = (c >= 4) && (c < 14);
            checks++;
            if (out_valid !== exp_valid) begin
                errors++; $display("FAIL stream_out_valid cycle %0d got %b required %b", c, out_valid, exp_valid);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [WIDTH-1:0] pa [6];
        logic [WIDTH-1:0] pb [6];
        logic             ps [6];
        logic [WIDTH-1:0] held_s;
        int               n_acc;
        for (int i = 0; i < 6; i++) begin
            pa[i] = $urandom;
            pb[i] = $urandom;
            ps[i] = 1'(i % 2);
        end
        n_acc = 0;
        held_s = '0;
        for (int c = 0; c < 8; c++) begin
            @(posedge clock); #1;
            out_ready = 1'b0;
            set_op(pa[n_acc], pb[n_acc], ps[n_acc], 1'b1);
            @(negedge clock);
            if (in_ready === 1'b1) begin
                sb.push_back(model(pa[n_acc], pb[n_acc], ps[n_acc]));
                n_acc++;
            end
            if (c == 4) held_s = s;
            if (c > 4) begin
                checks++;
                if (s !== held_s) begin
                    errors++; $display("FAIL stall_s_stable cycle %0d got %h required %h", c, s, held_s);
                end
            end
        end
        checks++;
        if (n_acc != 4) begin
            errors++; $display("FAIL stall_accepted got %0d required 4", n_acc);
        end
        checks++;
        if ({in_ready, out_valid} !== 2'b01) begin
            errors++; $display("FAIL stall_flags got in_ready=%b out_valid=%b required 0 1", in_ready, out_valid);
        end
        // Full pipeline released: accept and emit in the same cycle
        @(posedge clock); #1;
        out_ready = 1'b1;
        set_op(pa[n_acc], pb[n_acc], ps[n_acc], 1'b1);
        @(negedge clock);
        checks++;
        if ({in_ready, out_valid} !== 2'b11) begin
            errors++; $display("FAIL release_same_cycle got in_ready=%b out_valid=%b required 1 1", in_ready, out_valid);
        end
        if (in_ready === 1'b1) begin
            sb.push_back(model(pa[n_acc], pb[n_acc], ps[n_acc]));
            n_acc++;
        end
        for (int c = 0; c < 30 && (n_acc < 6 || sb.size() > 0); c++) begin
            @(posedge clock); #1;
            if (n_acc < 6) set_op(pa[n_acc], pb[n_acc], ps[n_acc], 1'b1);
            else           in_valid = 1'b0;
            @(negedge clock);
            if (in_valid && in_ready === 1'b1) begin
                sb.push_back(model(pa[n_acc], pb[n_acc], ps[n_acc]));
                n_acc++;
            end
        end
        @(posedge clock); #1;
        in_valid = 1'b0;
        checks++;
        if (n_acc != 6 || sb.size() != 0) begin
            errors++; $display("FAIL drain got accepted=%0d pending=%0d required 6 0", n_acc, sb.size());
        end
        repeat (6) @(posedge clock);
    endtask

    task automatic test_midstream_reset();
        logic [WIDTH-1:0] xa [3];
        logic [WIDTH-1:0] xb [3];
        logic             seen;
        int               lat;
        xa = '{32'h1111_1111, 32'h2222_2222, 32'h0F0F_0F0F};
        xb = '{32'h2222_2222, 32'h0101_0101, 32'h0000_0F0F};
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clock); #1;
            set_op(xa[i], xb[i], 1'b0, 1'b1);
            @(negedge clock);
            if (in_ready === 1'b1) sb.push_back(model(xa[i], xb[i], 1'b0));
        end
        @(posedge clock); #1;
        in_valid = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 10 && !seen; c++) begin
            @(negedge clock);
            if (out_valid === 1'b1) seen = 1'b1;
        end
        checks++;
        if (!seen) begin
            errors++; $display("FAIL midreset_fill got out_valid=0 required 1");
        end
        #2;
        reset = 1'b1;
        set_op(32'hDEAD_BEEF, 32'h1, 1'b0, 1'b1);
        #1;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++; $display("FAIL midreset_out_valid got %b required 0", out_valid);
        end
        checks++;
        if (s !== '0) begin
            errors++; $display("FAIL midreset_s got %h required 00000000", s);
        end
        sb.delete();
        @(posedge clock);
        @(posedge clock); #1;
        reset = 1'b0;
        in_valid = 1'b0;
        @(negedge clock);
        checks++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL midreset_in_ready got %b required 1", in_ready);
        end
        for (int c = 0; c < 6; c++) begin
            @(negedge clock);
            checks++;
            if (out_valid !== 1'b0) begin
                errors++; $display("FAIL midreset_stale cycle %0d got out_valid=%b required 0", c, out_valid);
            end
        end
        @(posedge clock); #1;
        set_op(32'd1, 32'd2, 1'b0, 1'b1);
        @(negedge clock);
        if (in_ready === 1'b1) sb.push_back(mk(32'd3, 1'b0, 1'b0, 1'b0));
        @(posedge clock); #1;
        in_valid = 1'b0;
        lat = 0;
        seen = 1'b0;
        for (int c = 1; c <= 10 && !seen; c++) begin
            @(negedge clock);
            if (out_valid === 1'b1) begin
                seen = 1'b1;
                lat = c;
            end
        end
        checks++;
        if (lat != 4) begin
            errors++; $display("FAIL midreset_latency got %0d required 4", lat);
        end
        @(posedge clock); #1;
        checks++;
        if (sb.size() != 0) begin
            errors++; $display("FAIL midreset_pending got %0d required 0", sb.size());
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_stream();
        test_backpressure();
        test_midstream_reset();
        repeat (3) @(posedge clock);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipelined_csel_addsub.md
Name: pipelined_csel_addsub

Overview:
- Parametrised, pipelined carry-select adder/subtractor; next generation of the team's 32-bit carry-select adder.
- Operand width and segment width are configurable.
- Each segment occupies one pipeline stage, and a registered carry ripples between stages.
- Valid/ready handshakes on both sides allow back-to-back throughput with backpressure; sits in front of the ALU result mux.

Parameters:
- WIDTH, 32, operand and result width in bits.
- SEG_W, 8, segment width; one pipeline stage per segment. WIDTH must be a multiple of SEG_W.
- NSEG, WIDTH/SEG_W, derived local value: stage count and latency; must be >= 1.

Ports:
- clock  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  operand set present.
- in_ready  output  1  block can accept an operand set this cycle.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- sub  input  1  0 = A+B, 1 = A-B.
- out_valid  output  1  result present.
- out_ready  input  1  consumer accepts the result this cycle.
- s  output  WIDTH  result.
- cout  output  1  carry out of the MSB. For subtraction, 1 means no borrow.
- ovf  output  1  signed overflow.
- zero  output  1  s == 0.

Behaviour:
- Operation:
  - Effective B is b XOR {WIDTH{sub}}; carry-in is sub. Arithmetic is modulo 2^WIDTH.
- Stage k (0..NSEG-1):
  - Computes segment k, bits [k*SEG_W +: SEG_W], twice: once with carry-in 0 and once with carry-in 1.
  - Selects between the two using the carry registered by stage k-1 (stage 0 uses sub).
  - Registers: the selected segment, its carry-out, the not-yet-processed upper operand segments, the completed lower sum segments, and a valid bit.
- Last stage also registers:
  - cout.
  - ovf = carry into MSB XOR carry out of MSB.
  - zero = (full sum == 0).
  - s, cout, ovf and zero are driven directly from last-stage registers, with no combinational path from a/b.
- Handshake:
  - Transfer in occurs when in_valid && in_ready; transfer out occurs when out_valid && out_ready.
  - Stage k advances when stage k is valid and (stage k+1 is empty or stage k+1 advances). The last stage advances on out_ready.
  - in_ready = !stage0_valid || stage0 advances. This is combinational from out_ready through the chain, with no bubbles.
  - out_valid = last-stage valid.
  - A stage that does not advance holds all its registers unchanged.
  - Outputs stay stable while out_valid && !out_ready.
- Latency and throughput:
  - Latency is exactly NSEG cycles from input accept to out_valid when there is no backpressure.
  - Throughput is 1 operation/cycle.
  - Capacity is NSEG operations.
  - Results appear in acceptance order.
- Reset (asynchronous, at any time, including mid-stream):
  - All valid bits clear immediately; in-flight operations are discarded.
  - s = 0, cout = 0, ovf = 0, zero = 0, out_valid = 0.
  - in_ready = 1 once reset is deasserted.
- Boundary conditions:
  - NSEG = 1 behaves as a single registered adder with latency 1.
  - Full pipeline with out_ready low: in_ready = 0.
  - Full pipeline with out_ready high in the same cycle as in_valid high: accept and emit in that same cycle.
  - in_valid while reset is asserted is ignored.

Test Plan:
- WIDTH=32, SEG_W=8: a=0x0000FFFF, b=0x00000001, sub=0 -> s=0x00010000, cout=0, ovf=0, zero=0, out_valid exactly 4 cycles after accept.
- sub=1, a=5, b=7 -> s=0xFFFFFFFE, cout=0, ovf=0. Then a=7, b=7 -> s=0, cout=1, zero=1.
- Add a=0x7FFFFFFF, b=1 -> s=0x80000000, ovf=1. Sub a=0x80000000, b=1 -> s=0x7FFFFFFF, ovf=1, cout=1. Add 0xFFFFFFFF+1 -> s=0, cout=1, ovf=0, zero=1.
- Stream 10 random operations with out_ready held high -> one result per cycle after the 4-cycle fill, in order, matching the reference model.
- out_ready held low while 6 operations are offered -> exactly 4 accepted, in_ready=0, s stable. Release out_ready -> remaining 2 accepted, all 6 results in order, none lost or duplicated.
- Assert reset with 3 operations in flight -> out_valid and s go to 0 immediately; after reset deasserts, no stale result appears and a new operation (1+2) returns s=3 after 4 cycles.
